imem_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the 32-entry combinational instruction memory (32-bit words, word index = address bits [4:0]).
- Owns the program counter and drives the IMEM word address.
- Registers the returned word into a single output slot with a valid/ready handshake to decode.
- Applies redirects and flags out-of-range or misaligned PCs.

---
 rtl/imem_pkg.sv | 29 ++
 rtl/imem_fetch_ctrl_if.sv | 36 +++
 rtl/imem_fetch_ctrl.sv | 141 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// ----------------------------------------------------------------------------
// imem_pkg
// Constants and types shared by the instruction-fetch controller, the
// combinational instruction memory and the decode stage.
//   XLEN        : PC / address width
//   INST_W      : instruction word width
//   IMEM_DEPTH  : number of IMEM words
//   IMEM_BYTES  : first byte PC past the end of IMEM
//   fetch_state_t : fetch sequencer states
// ----------------------------------------------------------------------------
package imem_pkg;

   localparam int XLEN       = 64;
   localparam int INST_W     = 32;
   localparam int IMEM_DEPTH = 32;
   localparam int IMEM_BYTES = 4 * IMEM_DEPTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;

   // Instructions are 32-bit words, so any byte PC with low bits set is illegal.
   function automatic logic pc_aligned(input logic [XLEN-1:0] pc);
      return (pc[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// imem_fetch_ctrl_if
// Bundles the fetch controller's IMEM bus, decode handshake, redirect and
// status signals.
//   master : the fetch controller (drives imem_addr, inst_*, status)
//   slave  : surrounding system (IMEM, decode, branch unit, control)
// ----------------------------------------------------------------------------
interface imem_fetch_ctrl_if;

   logic                        start;
   logic [imem_pkg::XLEN-1:0]   imem_addr;
   logic [imem_pkg::INST_W-1:0] imem_data;
   logic                        inst_valid;
   logic                        inst_ready;
   logic [imem_pkg::INST_W-1:0] inst_data;
   logic [imem_pkg::XLEN-1:0]   inst_pc;
   logic                        redirect_valid;
   logic [imem_pkg::XLEN-1:0]   redirect_pc;
   logic                        fault;
   logic [imem_pkg::XLEN-1:0]   fault_pc;
   logic                        busy;
   logic [31:0]                 fetch_count;

   modport master (
      input  start, imem_data, inst_ready, redirect_valid, redirect_pc,
      output imem_addr, inst_valid, inst_data, inst_pc, fault, fault_pc,
             busy, fetch_count
   );

   modport slave (
      output start, imem_data, inst_ready, redirect_valid, redirect_pc,
      input  imem_addr, inst_valid, inst_data, inst_pc, fault, fault_pc,
             busy, fetch_count
   );

endinterface

// File: rtl/imem_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// imem_fetch_ctrl
// Instruction-fetch sequencer. Owns the PC, addresses the combinational IMEM
// and registers the returned word into a one-entry valid/ready output slot.
// Handles redirects and raises a sticky fault on misaligned redirect targets
// or when fetching past the end of IMEM.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : imem_fetch_ctrl_if.master (IMEM bus, decode handshake,
//           redirect, fault / busy / fetch_count status)
// ----------------------------------------------------------------------------
module imem_fetch_ctrl
   import imem_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   imem_fetch_ctrl_if.master bus
);

   localparam logic [XLEN-1:0] LP_PC_LIMIT = XLEN'(IMEM_BYTES);
   localparam logic [XLEN-1:0] LP_PC_STEP  = XLEN'(4);

   fetch_state_t      r_state;
   fetch_state_t      w_state_nxt;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   w_pc_nxt;
   logic              r_vld_p1;
   logic              w_vld_nxt;
   logic [INST_W-1:0] r_inst_data_p1;
   logic [XLEN-1:0]   r_inst_pc_p1;
   logic              w_load_slot;
   logic              r_fault;
   logic              w_set_fault;
   logic [XLEN-1:0]   r_fault_pc;
   logic [XLEN-1:0]   w_fault_pc_nxt;
   logic [31:0]       r_fetch_count;

   logic              w_advance;
   logic              w_xfer;
   logic              w_pc_in_range;

   assign w_advance     = !r_vld_p1 || bus.inst_ready;
   assign w_xfer        = r_vld_p1 && bus.inst_ready;
   assign w_pc_in_range = (r_pc < LP_PC_LIMIT);

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      // Slot empties on a completed transfer unless refilled below.
      w_vld_nxt      = r_vld_p1 && !w_xfer;
      w_load_slot    = 1'b0;
      w_set_fault    = 1'b0;
      w_fault_pc_nxt = r_fault_pc;

      case (r_state)
         IDLE: begin
            if (bus.redirect_valid && !pc_aligned(bus.redirect_pc)) begin
               w_state_nxt    = FAULT;
               w_set_fault    = 1'b1;
               w_fault_pc_nxt = bus.redirect_pc;
            end else begin
               if (bus.redirect_valid) w_pc_nxt = bus.redirect_pc;
               if (bus.start)          w_state_nxt = RUN;
            end
         end
         RUN: begin
            // Redirect wins over fetch and flushes the slot even if it was
            // being accepted this cycle.
            if (bus.redirect_valid) begin
               w_vld_nxt = 1'b0;
               if (!pc_aligned(bus.redirect_pc)) begin
                  w_state_nxt    = FAULT;
                  w_set_fault    = 1'b1;
                  w_fault_pc_nxt = bus.redirect_pc;
               end else begin
                  w_pc_nxt = bus.redirect_pc;
               end
            end else if (w_advance) begin
               if (w_pc_in_range) begin
                  w_load_slot = 1'b1;
                  w_vld_nxt   = 1'b1;
                  w_pc_nxt    = r_pc + LP_PC_STEP;
               end else begin
                  w_state_nxt    = FAULT;
                  w_set_fault    = 1'b1;
                  w_fault_pc_nxt = r_pc;
               end
            end
         end
         FAULT: begin
            // Terminal: only a held instruction may still drain.
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Control state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_pc          <= RESET_PC;
         r_vld_p1      <= 1'b0;
         r_fault       <= 1'b0;
         r_fault_pc    <= '0;
         r_fetch_count <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_vld_p1   <= w_vld_nxt;
         r_fault_pc <= w_fault_pc_nxt;
         if (w_set_fault) r_fault       <= 1'b1;
         if (w_xfer)      r_fetch_count <= r_fetch_count + 32'd1;
      end
   end

   // Output slot stage (p1): word and its PC captured on each fetch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inst_data_p1 <= '0;
         r_inst_pc_p1   <= '0;
      end else if (w_load_slot) begin
         r_inst_data_p1 <= bus.imem_data;
         r_inst_pc_p1   <= r_pc;
      end
   end

   assign bus.imem_addr   = {2'b00, r_pc[XLEN-1:2]};
   assign bus.inst_valid  = r_vld_p1;
   assign bus.inst_data   = r_inst_data_p1;
   assign bus.inst_pc     = r_inst_pc_p1;
   assign bus.fault       = r_fault;
   assign bus.fault_pc    = r_fault_pc;
   assign bus.busy        = (r_state == RUN);
   assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
// Directed bench for imem_fetch_ctrl with a preloaded 32-word IMEM model.
// ----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;
   import imem_pkg::*;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic [INST_W-1:0] mem [IMEM_DEPTH];
   int                n_checks = 0;
   int                n_fail   = 0;

   imem_fetch_ctrl_if bus();

   imem_fetch_ctrl #(.RESET_PC('0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.imem_data = mem[bus.imem_addr[4:0]];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n              = 1'b0;
      bus.start          = 1'b0;
      bus.inst_ready     = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      step();
      rst_n = 1'b1;
   endtask

   // After this the slot holds the word at RESET_PC.
   task automatic start_run();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
   endtask

   initial begin
      logic [31:0] exp_data [5];
      exp_data[0] = 32'd15; exp_data[1] = 32'd64; exp_data[2] = 32'd89;
      exp_data[3] = 32'd1;  exp_data[4] = 32'd73;

      for (int i = 0; i < IMEM_DEPTH; i++) mem[i] = '0;
      mem[0] = 32'd15; mem[1] = 32'd64; mem[2] = 32'd89; mem[3] = 32'd1; mem[4] = 32'd73;
      for (int i = 5; i < 10; i++) mem[i] = 32'(i);

      bus.start          = 1'b0;
      bus.inst_ready     = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;

      // 1. reset values, then streaming
      step();
      chk("rst_valid", 64'(bus.inst_valid), 64'd0);
      chk("rst_data",  64'(bus.inst_data),  64'd0);
      chk("rst_busy",  64'(bus.busy),       64'd0);
      chk("rst_fault", 64'(bus.fault),      64'd0);
      chk("rst_count", 64'(bus.fetch_count), 64'd0);
      chk("rst_addr",  64'(bus.imem_addr),  64'd0);
      rst_n = 1'b1;
      bus.inst_ready = 1'b1;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("t1_busy",  64'(bus.busy),       64'd1);
      chk("t1_lat",   64'(bus.inst_valid), 64'd0);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("t1_valid", 64'(bus.inst_valid), 64'd1);
         chk("t1_data",  64'(bus.inst_data),  64'(exp_data[i]));
         chk("t1_pc",    64'(bus.inst_pc),    64'(4 * i));
         step();
      end
      chk("t1_count", 64'(bus.fetch_count), 64'd5);

      // 2. stall while holding pc=4
      do_reset();
      bus.inst_ready = 1'b1;
      start_run();
      step();
      chk("t2_pre_pc", 64'(bus.inst_pc), 64'd4);
      bus.inst_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_hold_valid", 64'(bus.inst_valid), 64'd1);
         chk("t2_hold_data",  64'(bus.inst_data),  64'd64);
         chk("t2_hold_pc",    64'(bus.inst_pc),    64'd4);
      end
      bus.inst_ready = 1'b1;
      step();
      chk("t2_next_data", 64'(bus.inst_data),   64'd89);
      chk("t2_next_pc",   64'(bus.inst_pc),     64'd8);
      chk("t2_count",     64'(bus.fetch_count), 64'd2);

      // 3. redirect to 16 during streaming
      do_reset();
      bus.inst_ready = 1'b1;
      start_run();
      step();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'd16;
      step();
      bus.redirect_valid = 1'b0;
      chk("t3_flush",  64'(bus.inst_valid),  64'd0);
      chk("t3_count",  64'(bus.fetch_count), 64'd2);
      step();
      chk("t3_valid",  64'(bus.inst_valid), 64'd1);
      chk("t3_data",   64'(bus.inst_data),  64'd73);
      chk("t3_pc",     64'(bus.inst_pc),    64'd16);
      step();
      chk("t3_data2",  64'(bus.inst_data),  64'd5);
      chk("t3_pc2",    64'(bus.inst_pc),    64'd20);

      // 4. misaligned redirect
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'd6;
      step();
      bus.redirect_valid = 1'b0;
      chk("t4_fault",    64'(bus.fault),      64'd1);
      chk("t4_fault_pc", 64'(bus.fault_pc),   64'd6);
      chk("t4_valid",    64'(bus.inst_valid), 64'd0);
      chk("t4_busy",     64'(bus.busy),       64'd0);
      bus.start = 1'b1;
      step();
      step();
      bus.start = 1'b0;
      chk("t4_stay_busy",  64'(bus.busy),       64'd0);
      chk("t4_stay_valid", 64'(bus.inst_valid), 64'd0);
      chk("t4_stay_fault", 64'(bus.fault),      64'd1);

      // 5. last legal word then out-of-range fault
      do_reset();
      bus.inst_ready = 1'b1;
      start_run();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'd120;
      step();
      bus.redirect_valid = 1'b0;
      step();
      chk("t5_pc120", 64'(bus.inst_pc), 64'd120);
      step();
      chk("t5_valid",  64'(bus.inst_valid), 64'd1);
      chk("t5_pc124",  64'(bus.inst_pc),    64'd124);
      chk("t5_data31", 64'(bus.inst_data),  64'd0);
      chk("t5_nofault",64'(bus.fault),      64'd0);
      step();
      chk("t5_fault",    64'(bus.fault),      64'd1);
      chk("t5_fault_pc", 64'(bus.fault_pc),   64'd128);
      chk("t5_flush",    64'(bus.inst_valid), 64'd0);
      chk("t5_addr",     64'(bus.imem_addr),  64'd32);
      chk("t5_busy",     64'(bus.busy),       64'd0);
      step();
      chk("t5_nowrap_valid", 64'(bus.inst_valid), 64'd0);
      chk("t5_nowrap_data",  64'(bus.inst_data),  64'd0);

      // 6. asynchronous reset mid-stream
      do_reset();
      bus.inst_ready = 1'b1;
      start_run();
      step();
      chk("t6_pre_valid", 64'(bus.inst_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_valid", 64'(bus.inst_valid),  64'd0);
      chk("t6_data",  64'(bus.inst_data),   64'd0);
      chk("t6_pc",    64'(bus.inst_pc),     64'd0);
      chk("t6_count", 64'(bus.fetch_count), 64'd0);
      chk("t6_busy",  64'(bus.busy),        64'd0);
      chk("t6_addr",  64'(bus.imem_addr),   64'd0);
      step();
      rst_n = 1'b1;
      start_run();
      chk("t6_restart_data", 64'(bus.inst_data), 64'd15);
      chk("t6_restart_pc",   64'(bus.inst_pc),   64'd0);

      // IDLE redirect loads pc without starting
      do_reset();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'd12;
      step();
      bus.redirect_valid = 1'b0;
      chk("idle_redir_busy", 64'(bus.busy),       64'd0);
      chk("idle_redir_addr", 64'(bus.imem_addr),  64'd3);
      step();
      chk("idle_redir_valid", 64'(bus.inst_valid), 64'd0);

      // simultaneous start and redirect in IDLE
      do_reset();
      bus.inst_ready     = 1'b1;
      bus.start          = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'd8;
      step();
      bus.start          = 1'b0;
      bus.redirect_valid = 1'b0;
      chk("sim_busy", 64'(bus.busy),      64'd1);
      chk("sim_addr", 64'(bus.imem_addr), 64'd2);
      step();
      chk("sim_data", 64'(bus.inst_data), 64'd89);
      chk("sim_pc",   64'(bus.inst_pc),   64'd8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
